// File: rtl/cnn_pkg.sv
// Shared types and default dimensions for the CNN streaming blocks.
package cnn_pkg;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_NUM_CHANNELS = 6;
    localparam int DEF_NUM_COLUMNS  = 28;
    localparam int DEF_NUM_ROWS     = 28;

    typedef logic signed [DEF_DATA_WIDTH-1:0] feature_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pool_state_e;

    // Index width for a range of `count` entries, never narrower than one bit.
    function automatic int addr_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/max_pool_stream_if.sv
// Valid/ready stream bundle around max_pool_stream: feature input, pooled output, frame control.
interface max_pool_stream_if
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                         start;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_last;
    logic                         busy;

    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );

endinterface

// File: rtl/pool_line_buf.sv
// Line buffer holding the top-row horizontal maxima: one write port, one combinational read port.
module pool_line_buf
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = (DEF_NUM_COLUMNS / 2) * DEF_NUM_CHANNELS,
    parameter int AW         = addr_width(DEPTH)
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic [AW-1:0]                waddr_i,
    input  logic signed [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]                raddr_i,
    output logic signed [DATA_WIDTH-1:0] rdata_o
);

    logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage arrays get no reset; every entry is written on the top row before the
    // bottom row reads it, and a reset port would stop the array mapping onto RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/max_pool_stream.sv
// 2x2 / stride-2 max pooling over a raster-ordered, channel-interleaved feature stream.
// Optional build macro MAX_POOL_RELU_EN clamps negative pooled results to zero at o_data.
module max_pool_stream
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH   = $bits(feature_t),
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int NUM_COLUMNS  = DEF_NUM_COLUMNS,
    parameter int NUM_ROWS     = DEF_NUM_ROWS
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic signed [DATA_WIDTH-1:0] o_data,
    output logic                         o_last,
    output logic                         o_busy
);

    localparam int LB_DEPTH = (NUM_COLUMNS / 2) * NUM_CHANNELS;
    localparam int LB_AW    = addr_width(LB_DEPTH);
    localparam int CH_W     = addr_width(NUM_CHANNELS);
    localparam int COL_W    = addr_width(NUM_COLUMNS);
    localparam int ROW_W    = addr_width(NUM_ROWS);

    typedef logic signed [DATA_WIDTH-1:0] data_t;

    // The earlier operand wins ties, so equal values never swap source.
    function automatic data_t pick_max(input data_t earlier, input data_t later);
        return (later > earlier) ? later : earlier;
    endfunction

    pool_state_e      state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    data_t            hold_q [NUM_CHANNELS];
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    data_t            out_data_q, out_data_d;

    logic             accept, ch_wrap, col_wrap, row_wrap;
    logic             odd_col, bottom_row, out_done;
    logic             hold_we, lb_we;
    logic [LB_AW-1:0] lb_addr;
    data_t            lb_rdata, hold_d, pair_max, out_value;

    assign accept     = i_valid & o_ready;
    assign ch_wrap    = (ch_q == CH_W'(NUM_CHANNELS - 1));
    assign col_wrap   = (col_q == COL_W'(NUM_COLUMNS - 1));
    assign row_wrap   = (row_q == ROW_W'(NUM_ROWS - 1));
    assign odd_col    = col_q[0];
    assign bottom_row = row_q[0];
    assign out_done   = out_valid_q & i_ready & out_last_q;
    assign lb_addr    = LB_AW'((int'(col_q) >> 1) * NUM_CHANNELS + int'(ch_q));

    // Even column opens a pair in the hold register; odd column closes it.
    assign pair_max = pick_max(hold_q[ch_q], i_data);
    assign hold_d   = bottom_row ? pick_max(lb_rdata, i_data) : i_data;
    assign hold_we  = accept & ~odd_col;
    assign lb_we    = accept & ~bottom_row & odd_col;

`ifdef MAX_POOL_RELU_EN
    assign out_value = pair_max[DATA_WIDTH-1] ? '0 : pair_max;
`else
    assign out_value = pair_max;
`endif

    pool_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (LB_DEPTH),
        .AW         (LB_AW)
    ) u_line_buf (
        .clk     (i_clk),
        .we_i    (lb_we),
        .waddr_i (lb_addr),
        .wdata_i (pair_max),
        .raddr_i (lb_addr),
        .rdata_o (lb_rdata)
    );

    // FSM: state register.
    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process order; combinational blocks use blocking.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic.
    // NOTE: every combinational output gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = RUN;
            RUN:     if (out_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        o_busy  = (state_q == RUN);
        o_ready = (state_q == RUN) & (~out_valid_q | i_ready);
    end

    always_comb begin
        ch_d  = ch_q;
        col_d = col_q;
        row_d = row_q;
        if (state_q == IDLE) begin
            if (i_start) begin
                ch_d  = '0;
                col_d = '0;
                row_d = '0;
            end
        end else if (accept) begin
            if (!ch_wrap) begin
                ch_d = ch_q + 1'b1;
            end else begin
                ch_d = '0;
                if (!col_wrap) begin
                    col_d = col_q + 1'b1;
                end else begin
                    col_d = '0;
                    row_d = row_wrap ? '0 : row_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        if (out_valid_q && i_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (accept && bottom_row && odd_col) begin
            out_valid_d = 1'b1;
            out_data_d  = out_value;
            out_last_d  = row_wrap & col_wrap & ch_wrap;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ch_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            ch_q        <= ch_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // Hold values are always written on the even column before the odd column reads them.
    always_ff @(posedge i_clk) begin
        if (hold_we) begin
            hold_q[ch_q] <= hold_d;
        end
    end

    assign o_valid = out_valid_q;
    assign o_last  = out_last_q;
    assign o_data  = out_data_q;

    even_dims_a: assert property (@(posedge i_clk) (NUM_COLUMNS % 2 == 0) && (NUM_ROWS % 2 == 0))
        else $error("max_pool_stream: NUM_COLUMNS and NUM_ROWS must be even");

endmodule

// File: tb/tb_max_pool_stream.sv
// Self-checking bench: three max_pool_stream configurations (1ch 4x4, 2ch 2x2, default 28x28x6)
// driven through one shared stimulus path and checked against a window-max reference model.
module tb_max_pool_stream;
    import cnn_pkg::*;

    localparam int DW = DEF_DATA_WIDTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int                   sel;
    logic                 start, valid, ready;
    logic signed [DW-1:0] data;

    logic                 obs_valid, obs_ready, obs_last, obs_busy;
    logic signed [DW-1:0] obs_data;

    logic signed [DW-1:0] in_q [$];
    logic signed [DW-1:0] exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    max_pool_stream_if #(.DATA_WIDTH(DW)) if_a ();
    max_pool_stream_if #(.DATA_WIDTH(DW)) if_b ();
    max_pool_stream_if #(.DATA_WIDTH(DW)) if_c ();

    assign if_a.start     = start & (sel == 0);
    assign if_a.in_valid  = valid & (sel == 0);
    assign if_a.in_data   = data;
    assign if_a.out_ready = ready & (sel == 0);
    assign if_b.start     = start & (sel == 1);
    assign if_b.in_valid  = valid & (sel == 1);
    assign if_b.in_data   = data;
    assign if_b.out_ready = ready & (sel == 1);
    assign if_c.start     = start & (sel == 2);
    assign if_c.in_valid  = valid & (sel == 2);
    assign if_c.in_data   = data;
    assign if_c.out_ready = ready & (sel == 2);

    max_pool_stream #(.DATA_WIDTH(DW), .NUM_CHANNELS(1), .NUM_COLUMNS(4), .NUM_ROWS(4)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(if_a.start), .i_valid(if_a.in_valid),
        .o_ready(if_a.in_ready), .i_data(if_a.in_data), .o_valid(if_a.out_valid),
        .i_ready(if_a.out_ready), .o_data(if_a.out_data), .o_last(if_a.out_last),
        .o_busy(if_a.busy)
    );

    max_pool_stream #(.DATA_WIDTH(DW), .NUM_CHANNELS(2), .NUM_COLUMNS(2), .NUM_ROWS(2)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(if_b.start), .i_valid(if_b.in_valid),
        .o_ready(if_b.in_ready), .i_data(if_b.in_data), .o_valid(if_b.out_valid),
        .i_ready(if_b.out_ready), .o_data(if_b.out_data), .o_last(if_b.out_last),
        .o_busy(if_b.busy)
    );

    max_pool_stream #(.DATA_WIDTH(DW)) u_dut_c (
        .i_clk(clk), .i_rst(rst), .i_start(if_c.start), .i_valid(if_c.in_valid),
        .o_ready(if_c.in_ready), .i_data(if_c.in_data), .o_valid(if_c.out_valid),
        .i_ready(if_c.out_ready), .o_data(if_c.out_data), .o_last(if_c.out_last),
        .o_busy(if_c.busy)
    );

    always_comb begin
        case (sel)
            0: begin
                obs_valid = if_a.out_valid; obs_ready = if_a.in_ready; obs_last = if_a.out_last;
                obs_busy  = if_a.busy;      obs_data  = if_a.out_data;
            end
            1: begin
                obs_valid = if_b.out_valid; obs_ready = if_b.in_ready; obs_last = if_b.out_last;
                obs_busy  = if_b.busy;      obs_data  = if_b.out_data;
            end
            default: begin
                obs_valid = if_c.out_valid; obs_ready = if_c.in_ready; obs_last = if_c.out_last;
                obs_busy  = if_c.busy;      obs_data  = if_c.out_data;
            end
        endcase
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Reference: each output is the largest of its four window pixels, in pooled raster order.
    function automatic void build_model(input int rows, input int cols, input int chs);
        logic signed [DW-1:0] m, p;
        exp_q.delete();
        for (int pr = 0; pr < rows / 2; pr++) begin
            for (int pc = 0; pc < cols / 2; pc++) begin
                for (int ch = 0; ch < chs; ch++) begin
                    m = in_q[((2 * pr) * cols + 2 * pc) * chs + ch];
                    for (int dr = 0; dr < 2; dr++) begin
                        for (int dc = 0; dc < 2; dc++) begin
                            p = in_q[((2 * pr + dr) * cols + 2 * pc + dc) * chs + ch];
                            if (p > m) m = p;
                        end
                    end
`ifdef MAX_POOL_RELU_EN
                    if (m < 0) m = '0;
`endif
                    exp_q.push_back(m);
                end
            end
        end
    endfunction

    task automatic random_frame(input int n);
        in_q.delete();
        for (int i = 0; i < n; i++) in_q.push_back(DW'($urandom));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, obs_valid, 0);
        check({tag, "_last"},  obs_last,  0);
        check({tag, "_data"},  obs_data,  0);
        check({tag, "_ready"}, obs_ready, 0);
        check({tag, "_busy"},  obs_busy,  0);
    endtask

    // Streams in_q into DUT `s`; called and returns at a falling edge.
    task automatic run_frame(input int s, input int rows, input int cols, input int chs,
                             input int gap_pct, input int stall_pct, input int stall_first,
                             input bit start_noise, input int abort_at);
        int idx = 0;
        int n_out = 0;
        int stalled = 0;
        int cyc = 0;
        int budget;
        bit hold_chk, in_acc, out_acc;
        budget = 40 * in_q.size() + 200;
        build_model(rows, cols, chs);
        sel = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while ((idx < in_q.size() || n_out < exp_q.size()) && cyc < budget) begin
            if (abort_at >= 0 && idx >= abort_at) break;
            valid = (idx < in_q.size()) && ($urandom_range(99) >= gap_pct);
            data  = valid ? in_q[idx] : DW'($urandom);
            hold_chk = (stalled < stall_first) && (stalled > 0 || (obs_valid && n_out == 0));
            ready = hold_chk ? 1'b0 : ($urandom_range(99) >= stall_pct);
            if (hold_chk) stalled++;
            if (start_noise) start = 1'($urandom_range(1));
            #4;
            in_acc  = valid && obs_ready;
            out_acc = obs_valid && ready;
            if (hold_chk) begin
                check("stall_valid", obs_valid, 1);
                check("stall_data",  obs_data,  exp_q[0]);
                check("stall_ready", obs_ready, 0);
            end
            if (out_acc) begin
                if (n_out < exp_q.size()) begin
                    check($sformatf("out_data[%0d]", n_out), obs_data, exp_q[n_out]);
                    check($sformatf("out_last[%0d]", n_out), obs_last, n_out == exp_q.size() - 1);
                end else begin
                    check("extra_output", n_out, exp_q.size());
                end
                n_out++;
            end
            if (in_acc) idx++;
            cyc++;
            @(negedge clk);
        end
        valid = 1'b0;
        ready = 1'b0;
        start = 1'b0;
        if (abort_at < 0) begin
            check("in_count",   idx,      in_q.size());
            check("out_count",  n_out,    exp_q.size());
            check("idle_after", obs_busy, 0);
        end
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_vals [8] = '{-5, 7, -3, 7, -9, 2, -4, 1};
        rst = 1'b1; start = 1'b0; valid = 1'b0; ready = 1'b0; data = '0; sel = 0;

        // Reset state of every configuration.
        #12;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_idle_outputs($sformatf("reset%0d", s));
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1 channel, 4x4 ramp 1..16.
        in_q.delete();
        for (int i = 1; i <= 16; i++) in_q.push_back(DW'(i));
        run_frame(0, 4, 4, 1, 0, 0, 0, 1'b0, -1);

        // 2 channels, 2x2, negatives and ties.
        in_q.delete();
        foreach (b_vals[i]) in_q.push_back(DW'(b_vals[i]));
        run_frame(1, 2, 2, 2, 0, 0, 0, 1'b0, -1);

        // Five-cycle downstream stall on the first output.
        random_frame(16);
        run_frame(0, 4, 4, 1, 0, 0, 5, 1'b0, -1);

        // i_valid while IDLE is ignored; i_start during RUN is ignored.
        sel = 0;
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1; data = DW'($urandom); ready = 1'b1;
            #4;
            check("idle_ready", obs_ready, 0);
            check("idle_valid", obs_valid, 0);
            check("idle_busy",  obs_busy,  0);
            @(negedge clk);
        end
        valid = 1'b0; ready = 1'b0;
        random_frame(16);
        run_frame(0, 4, 4, 1, 20, 20, 0, 1'b1, -1);

        // Default geometry with random input gaps and output stalls.
        random_frame(28 * 28 * 6);
        run_frame(2, 28, 28, 6, 30, 20, 0, 1'b0, -1);

        // Reset during row 3, then a fresh full frame.
        random_frame(28 * 28 * 6);
        run_frame(2, 28, 28, 6, 10, 10, 0, 1'b0, 3 * 28 * 6 + 10);
        check("pre_reset_busy", obs_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_busy",  obs_busy,  0);
        check("post_reset_ready", obs_ready, 0);
        check("post_reset_valid", obs_valid, 0);
        random_frame(28 * 28 * 6);
        run_frame(2, 28, 28, 6, 25, 25, 0, 1'b1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/max_pool_stream.md
MAX_POOL_STREAM -- requirements
Module: max_pool_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: signed feature width.
REQ-002 SHALL have parameter NUM_CHANNELS, default 6: channels interleaved per pixel.
REQ-003 SHALL have parameter NUM_COLUMNS, default 28: input columns; even, >=2.
REQ-004 SHALL have parameter NUM_ROWS, default 28: input rows; even, >=2.
REQ-005 SHALL have port i_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port i_start, input, 1: frame start pulse; sampled in IDLE only.
REQ-008 SHALL have port i_valid, input, 1: i_data valid.
REQ-009 SHALL have port o_ready, output, 1: block accepts the input beat.
REQ-010 SHALL have port i_data, input, DATA_WIDTH: signed input feature.
REQ-011 SHALL have port o_valid, output, 1: o_data valid.
REQ-012 SHALL have port i_ready, input, 1: downstream accepts the output beat.
REQ-013 SHALL have port o_data, output, DATA_WIDTH: signed pooled feature.
REQ-014 SHALL have port o_last, output, 1: final output beat of the frame.
REQ-015 SHALL have port o_busy, output, 1: high in RUN.

Function
REQ-016 SHALL use a 2x2 window with stride 2; input in raster order (row, column, channel innermost); output in the same order over (NUM_ROWS/2)x(NUM_COLUMNS/2)xNUM_CHANNELS.
REQ-017 SHALL implement FSM IDLE->RUN on i_start; RUN->IDLE when the o_last beat is accepted (o_valid&i_ready&o_last).
REQ-018 SHALL hold o_ready low in IDLE; in RUN o_ready = ~o_valid | i_ready.
REQ-019 SHALL accept an input beat only when i_valid&o_ready; ch/col/row counters advance only on accept, ch wrapping to col, col wrapping to row.
REQ-020 SHALL on a top-row even column store the feature in a per-channel hold register; on a top-row odd column write max(hold, in) to the line buffer at index (col/2)*NUM_CHANNELS+ch.
REQ-021 SHALL on a bottom-row even column set hold = max(line buffer entry, in); on a bottom-row odd column register max(hold, in) into o_data with o_valid=1, one cycle after accept.
REQ-022 SHALL use signed comparison; ties keep the earlier value; no width growth.
REQ-023 SHALL hold o_data/o_valid/o_last stable while o_valid&~i_ready.
REQ-024 SHALL drive o_last high only on the output for the last row pair, last column pair, channel NUM_CHANNELS-1.
REQ-025 SHALL ignore i_start in RUN; i_valid in IDLE SHALL be ignored and not counted.
REQ-026 SHALL reset counters to zero on entering RUN; line buffer contents need no clearing, since every entry is written before it is read.

Reset
REQ-027 SHALL on i_rst, at any time including mid-frame, force IDLE, clear counters, and drive o_valid=0, o_last=0, o_data=0, o_ready=0, o_busy=0.
REQ-028 SHALL discard any partial frame on reset and require a new i_start.

Configuration
REQ-029 SHALL, with macro MAX_POOL_RELU_EN defined, clamp each negative output to 0 at the o_data register; without it, pass the pooled value through unchanged.

Structure
REQ-030 SHALL take the feature_t typedef (signed DATA_WIDTH), the pool_state_e enum (IDLE, RUN) and the default dimension constants from package cnn_pkg.
REQ-031 SHALL place the line buffer in sub-module pool_line_buf: single-port write / single-port read, depth (NUM_COLUMNS/2)*NUM_CHANNELS, combinational read.
REQ-032 SHALL assert in simulation that NUM_COLUMNS and NUM_ROWS are even.

Verification
REQ-033 SHALL check NUM_CHANNELS=1, 4x4 input 1..16 raster, i_ready=1 -> outputs 6,8,14,16; o_last on 16; back to IDLE.
REQ-034 SHALL check NUM_CHANNELS=2, 2x2 input, ch0 {-5,-3,-9,-4}, ch1 {7,7,2,1} -> outputs -3 then 7 (-3 becomes 0 with MAX_POOL_RELU_EN).
REQ-035 SHALL check that holding i_ready=0 for 5 cycles at the first output keeps o_valid=1, o_data constant and o_ready=0; no beats are lost or duplicated.
REQ-036 SHALL check that random i_valid gaps on a default 28x28x6 frame produce outputs matching the reference model in order.
REQ-037 SHALL check that asserting i_rst mid-frame (row 3) gives all outputs 0 and IDLE next cycle; a new i_start then a full frame gives correct results.
REQ-038 SHALL check that i_start pulsed in RUN and i_valid in IDLE have no effect on counters or outputs.
